// File: rtl/parity_pkg.sv
// Shared types and constants for the serial parity checker.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Wide enough for a population count of a 16-bit word
  localparam int ONES_W = 5;

  // High when the word plus its parity bit violates the requested parity
  function automatic logic parity_fail(input logic cnt_lsb, input logic par, input logic mode);
    return cnt_lsb ^ par ^ mode;
  endfunction

endpackage

// File: rtl/parity_check_datapath.sv
// Shift/count datapath: serially counts ones in the captured word and
// registers the parity verdict when the controller strobes check_en.
module parity_check_datapath
  import parity_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift_en,
  input  logic              check_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              parity_in,
  input  logic              parity_mode,
  output logic              last_bit,
  output logic              done,
  output logic              parity_ok,
  output logic              parity_err,
  output logic [ONES_W-1:0] ones_count
);

  localparam int IDX_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] shift_reg;
  logic [ONES_W-1:0] count;
  logic [IDX_W-1:0]  bit_idx;
  logic              par_q;
  logic              mode_q;

  assign last_bit = (bit_idx == IDX_W'(DATA_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg  <= '0;
      count      <= '0;
      bit_idx    <= '0;
      par_q      <= 1'b0;
      mode_q     <= 1'b0;
      done       <= 1'b0;
      parity_ok  <= 1'b0;
      parity_err <= 1'b0;
      ones_count <= '0;
    end else begin
      done <= 1'b0;
      if (load) begin
        shift_reg <= data_in;
        par_q     <= parity_in;
        mode_q    <= parity_mode;
        count     <= '0;
        bit_idx   <= '0;
      end else if (shift_en) begin
        count     <= count + {{(ONES_W-1){1'b0}}, shift_reg[0]};
        shift_reg <= shift_reg >> 1;
        bit_idx   <= bit_idx + IDX_W'(1);
      end
      // Result registers only move here, so they hold between done pulses
      if (check_en) begin
        parity_err <= parity_fail(count[0], par_q, mode_q);
        parity_ok  <= ~parity_fail(count[0], par_q, mode_q);
        ones_count <= count;
        done       <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/parity_checker.sv
// Serial parity checker: IDLE/SHIFT/CHECK controller around the datapath.
// Optional failure counter enabled by defining PARITY_CHECKER_ERR_CNT_EN.
module parity_checker
  import parity_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              parity_in,
  input  logic              parity_mode,
  output logic              busy,
  output logic              done,
  output logic              parity_ok,
  output logic              parity_err,
  output logic [ONES_W-1:0] ones_count
`ifdef PARITY_CHECKER_ERR_CNT_EN
  ,
  input  logic              err_cnt_clr,
  output logic [7:0]        err_count
`endif
);

  state_t state, next_state;
  logic   load, shift_en, check_en, last_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (last_bit) next_state = CHECK;
      CHECK:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // busy is decoded from state so an async reset drops it at once
  always_comb begin
    busy     = 1'b0;
    load     = 1'b0;
    shift_en = 1'b0;
    check_en = 1'b0;
    case (state)
      IDLE:    load = start;
      SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
      end
      CHECK: begin
        busy     = 1'b1;
        check_en = 1'b1;
      end
      default: ;
    endcase
  end

  parity_check_datapath #(.DATA_W(DATA_W)) u_dp (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .shift_en   (shift_en),
    .check_en   (check_en),
    .data_in    (data_in),
    .parity_in  (parity_in),
    .parity_mode(parity_mode),
    .last_bit   (last_bit),
    .done       (done),
    .parity_ok  (parity_ok),
    .parity_err (parity_err),
    .ones_count (ones_count)
  );

`ifdef PARITY_CHECKER_ERR_CNT_EN
  // Saturating count of failed checks; clear wins over a coincident failure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          err_count <= '0;
    else if (err_cnt_clr)                                err_count <= '0;
    else if (done && parity_err && err_count != 8'hFF)   err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_parity_checker.sv
// Randomized self-checking bench for parity_checker against a popcount model.
module tb_parity_checker;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [DATA_W-1:0] data_in;
  logic              parity_in;
  logic              parity_mode;
  logic              busy, done, parity_ok, parity_err;
  logic [4:0]        ones_count;
`ifdef PARITY_CHECKER_ERR_CNT_EN
  logic              err_cnt_clr;
  logic [7:0]        err_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  parity_checker #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .data_in    (data_in),
    .parity_in  (parity_in),
    .parity_mode(parity_mode),
    .busy       (busy),
    .done       (done),
    .parity_ok  (parity_ok),
    .parity_err (parity_err),
    .ones_count (ones_count)
`ifdef PARITY_CHECKER_ERR_CNT_EN
    ,
    .err_cnt_clr(err_cnt_clr),
    .err_count  (err_count)
`endif
  );

  // Reference model: plain popcount and parity rule
  function automatic int ref_ones(input logic [DATA_W-1:0] d);
    int n = 0;
    for (int i = 0; i < DATA_W; i++) n += int'(d[i]);
    return n;
  endfunction

  function automatic logic ref_err(input logic [DATA_W-1:0] d, input logic p, input logic m);
    // even mode wants an even total of ones (data + parity bit), odd mode an odd one
    return ((ref_ones(d) + int'(p)) % 2) != int'(m);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full check; optionally scrambles inputs and pokes start while busy
  task automatic run_check(input logic [DATA_W-1:0] d, input logic p, input logic m,
                           input bit garble, input string tag);
    int  lat;
    bit  seen;
    int  exp_ones;
    logic exp_err;
    exp_ones = ref_ones(d);
    exp_err  = ref_err(d, p, m);
    data_in = d; parity_in = p; parity_mode = m; start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_after_accept got=%b want=1", tag, busy); end
    lat = 0; seen = 0;
    while (!seen && lat < 40) begin
      if (garble) begin
        data_in     = DATA_W'($urandom);
        parity_in   = 1'($urandom);
        parity_mode = 1'($urandom);
        start       = ($urandom_range(0, 3) == 0);
      end
      step();
      lat++;
      if (done === 1'b1) seen = 1;
    end
    start = 1'b0;
    total++;
    if (lat != DATA_W + 1) begin bad++; $display("FAIL %s latency got=%0d want=%0d", tag, lat, DATA_W + 1); end
    total++;
    if (parity_err !== exp_err || parity_ok !== !exp_err) begin
      bad++; $display("FAIL %s verdict d=%h p=%b m=%b got ok=%b err=%b want err=%b", tag, d, p, m, parity_ok, parity_err, exp_err);
    end
    total++;
    if (ones_count !== 5'(exp_ones)) begin bad++; $display("FAIL %s ones_count got=%0d want=%0d", tag, ones_count, exp_ones); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_at_done got=%b want=0", tag, busy); end
    step();
    total++;
    if (done !== 1'b0 || parity_err !== exp_err || ones_count !== 5'(exp_ones)) begin
      bad++; $display("FAIL %s hold_after_done got done=%b err=%b ones=%0d want done=0 err=%b ones=%0d", tag, done, parity_err, ones_count, exp_err, exp_ones);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; data_in = '0; parity_in = 1'b0; parity_mode = 1'b0;
`ifdef PARITY_CHECKER_ERR_CNT_EN
    err_cnt_clr = 1'b0;
`endif
    #13;
    total++;
    if ({busy, done, parity_ok, parity_err, ones_count} !== 9'b0) begin
      bad++; $display("FAIL reset_state got busy=%b done=%b ok=%b err=%b ones=%0d want all 0", busy, done, parity_ok, parity_err, ones_count);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_directed();
    run_check(8'hA5, 1'b0, 1'b0, 0, "a5_even");
    run_check(8'h07, 1'b0, 1'b0, 0, "07_even");
    run_check(8'h07, 1'b0, 1'b1, 0, "07_odd");
    run_check(8'h00, 1'b1, 1'b1, 0, "00_odd");
    run_check(8'hFF, 1'b1, 1'b0, 0, "ff_even_bad");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_check(DATA_W'($urandom), 1'($urandom), 1'($urandom), 1, "random");
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  task automatic test_start_while_busy();
    int dones = 0;
    data_in = 8'hFF; parity_in = 1'b0; parity_mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    data_in = 8'h01; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1) begin
        dones++;
        total++;
        if (ones_count !== 5'd8 || parity_ok !== 1'b1) begin
          bad++; $display("FAIL busy_ignore result got ones=%0d ok=%b want ones=8 ok=1", ones_count, parity_ok);
        end
      end
      step();
    end
    total++;
    if (dones != 1) begin bad++; $display("FAIL busy_ignore done_count got=%0d want=1", dones); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL busy_ignore idle_after got busy=%b want=0", busy); end
  endtask

  task automatic test_back_to_back();
    int gap = 0;
    bit seen = 0;
    data_in = 8'h07; parity_in = 1'b0; parity_mode = 1'b0; start = 1'b1;
    step();
    for (int i = 0; i < 40 && !seen; i++) begin step(); if (done === 1'b1) seen = 1; end
    total++;
    if (!seen || parity_err !== 1'b1 || ones_count !== 5'd3) begin
      bad++; $display("FAIL b2b first got seen=%0d err=%b ones=%0d want seen=1 err=1 ones=3", seen, parity_err, ones_count);
    end
    // start still high during the done cycle: second word accepted on this edge
    data_in = 8'h0F; parity_in = 1'b1; parity_mode = 1'b1;
    step();
    start = 1'b0;
    gap = 1; seen = 0;
    while (!seen && gap < 40) begin step(); gap++; if (done === 1'b1) seen = 1; end
    total++;
    if (gap != DATA_W + 2) begin bad++; $display("FAIL b2b done_gap got=%0d want=%0d", gap, DATA_W + 2); end
    total++;
    if (parity_ok !== 1'b1 || ones_count !== 5'd4) begin
      bad++; $display("FAIL b2b second got ok=%b ones=%0d want ok=1 ones=4", parity_ok, ones_count);
    end
    step();
  endtask

  task automatic test_mid_reset();
    int dones = 0;
    data_in = 8'hFF; parity_in = 1'b1; parity_mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, parity_ok, parity_err, ones_count} !== 9'b0) begin
      bad++; $display("FAIL mid_reset state got busy=%b done=%b ok=%b err=%b ones=%0d want all 0", busy, done, parity_ok, parity_err, ones_count);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin step(); if (done === 1'b1) dones++; end
    total++;
    if (dones != 0) begin bad++; $display("FAIL mid_reset spurious_done got=%0d want=0", dones); end
    run_check(8'h01, 1'b1, 1'b0, 0, "after_reset");
  endtask

`ifdef PARITY_CHECKER_ERR_CNT_EN
  task automatic test_err_count();
    bit seen = 0;
    for (int i = 0; i < 300; i++) run_check(8'h07, 1'b0, 1'b0, 0, "errcnt");
    total++;
    if (err_count !== 8'd255) begin bad++; $display("FAIL err_count_sat got=%0d want=255", err_count); end
    data_in = 8'h07; parity_in = 1'b0; parity_mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin step(); if (done === 1'b1) seen = 1; end
    err_cnt_clr = 1'b1;
    step();
    err_cnt_clr = 1'b0;
    total++;
    if (!seen || err_count !== 8'd0) begin bad++; $display("FAIL err_count_clr got=%0d seen=%0d want=0", err_count, seen); end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_mid_reset();
`ifdef PARITY_CHECKER_ERR_CNT_EN
    test_err_count();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
